// File: rtl/two_col_psum_accumulator.sv
// Two-column partial-sum accumulator with show-ahead output FIFO and early feeder stall.
// Optional macro PSUM_SATURATE_EN: saturating column adds plus a per-entry out_sat flag.
module two_col_psum_accumulator #(
  parameter int IN_DW      = 21,
  parameter int ACC_DW     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAC_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [CNT_W-1:0]      cfg_k_iter,
  input  logic [CNT_W-1:0]      cfg_num_out,
  input  logic                  in_vld,
  input  logic [2*IN_DW-1:0]    in_dat,
  output logic                  in_stall,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [2*ACC_DW-1:0]   out_dat,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
`ifdef PSUM_SATURATE_EN
  output logic                  out_sat,
`endif
  output logic                  err
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int FCNT_W   = PTR_W + 1;
  localparam int STALL_TH = FIFO_DEPTH - MAC_LAT - 1;
`ifdef PSUM_SATURATE_EN
  localparam int ENT_W    = 2*ACC_DW + 2;
`else
  localparam int ENT_W    = 2*ACC_DW + 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   k_iter_q, k_iter_d;
  logic [CNT_W-1:0]   num_out_q, num_out_d;
  logic [CNT_W-1:0]   k_cnt_q, k_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [ACC_DW-1:0]  acc0_q, acc0_d;
  logic [ACC_DW-1:0]  acc1_q, acc1_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               stall_q, stall_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  logic [ACC_DW-1:0]  ext0, ext1, sum0, sum1;
  logic               push, push_last, wr_en, pop, fifo_full;
  logic [ENT_W-1:0]   wr_entry, head;

`ifdef PSUM_SATURATE_EN
  logic sat_acc_q, sat_acc_d;
  logic sat0, sat1, sat_run;

  // Returns {saturated, value}; overflow is detected on the extra sign bit.
  function automatic logic [ACC_DW:0] add_sat(input logic [ACC_DW-1:0] a,
                                               input logic [ACC_DW-1:0] b);
    logic [ACC_DW:0] w;
    w = {a[ACC_DW-1], a} + {b[ACC_DW-1], b};
    if (w[ACC_DW] != w[ACC_DW-1])
      return {1'b1, w[ACC_DW], {(ACC_DW-1){~w[ACC_DW]}}};
    return {1'b0, w[ACC_DW-1:0]};
  endfunction
`endif

  // Column datapath: the first chunk of a point loads, later chunks add.
  always_comb begin
    ext0 = ACC_DW'($signed(in_dat[IN_DW-1:0]));
    ext1 = ACC_DW'($signed(in_dat[2*IN_DW-1:IN_DW]));
`ifdef PSUM_SATURATE_EN
    {sat0, sum0} = add_sat(acc0_q, ext0);
    {sat1, sum1} = add_sat(acc1_q, ext1);
    sat_run      = sat_acc_q | sat0 | sat1;
    if (k_cnt_q == '0) begin
      sum0    = ext0;
      sum1    = ext1;
      sat_run = 1'b0;
    end
`else
    if (k_cnt_q == '0) begin
      sum0 = ext0;
      sum1 = ext1;
    end else begin
      sum0 = acc0_q + ext0;
      sum1 = acc1_q + ext1;
    end
`endif
  end

  assign out_vld   = (fcnt_q != '0);
  assign pop       = out_vld & out_rdy;
  assign fifo_full = (fcnt_q == FCNT_W'(FIFO_DEPTH));
  assign wr_en     = push & ~fifo_full;

  always_comb begin
    state_d   = state_q;
    k_iter_d  = k_iter_q;
    num_out_d = num_out_q;
    k_cnt_d   = k_cnt_q;
    out_cnt_d = out_cnt_q;
    acc0_d    = acc0_q;
    acc1_d    = acc1_q;
    err_d     = err_q;
    done_d    = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
`ifdef PSUM_SATURATE_EN
    sat_acc_d = sat_acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          k_iter_d  = (cfg_k_iter == '0) ? CNT_W'(1) : cfg_k_iter;
          num_out_d = cfg_num_out;
          k_cnt_d   = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = (cfg_num_out == '0) ? DRAIN : ACCUM;
        end
        if (in_vld)
          err_d = 1'b1;
      end

      ACCUM: begin
        if (in_vld) begin
          acc0_d = sum0;
          acc1_d = sum1;
`ifdef PSUM_SATURATE_EN
          sat_acc_d = sat_run;
          if ((k_cnt_q != '0) && (sat0 | sat1))
            err_d = 1'b1;
`endif
          if (k_cnt_q == k_iter_q - CNT_W'(1)) begin
            push      = 1'b1;
            push_last = (out_cnt_q == num_out_q - CNT_W'(1));
            k_cnt_d   = '0;
            out_cnt_d = out_cnt_q + CNT_W'(1);
            if (push_last)
              state_d = DRAIN;
          end else begin
            k_cnt_d = k_cnt_q + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        if (in_vld)
          err_d = 1'b1;
        if (fcnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A completed pair arriving at a full FIFO is lost, never overwritten.
    if (push && fifo_full)
      err_d = 1'b1;
  end

`ifdef PSUM_SATURATE_EN
  assign wr_entry = {sat_run, push_last, sum1, sum0};
`else
  assign wr_entry = {push_last, sum1, sum0};
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (wr_en)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
    // Threshold leaves room for the registered delay plus MAC_LAT in-flight sums.
    stall_d = (fcnt_q >= FCNT_W'(STALL_TH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_iter_q  <= '0;
      num_out_q <= '0;
      k_cnt_q   <= '0;
      out_cnt_q <= '0;
      acc0_q    <= '0;
      acc1_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      stall_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
`ifdef PSUM_SATURATE_EN
      sat_acc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_iter_q  <= k_iter_d;
      num_out_q <= num_out_d;
      k_cnt_q   <= k_cnt_d;
      out_cnt_q <= out_cnt_d;
      acc0_q    <= acc0_d;
      acc1_q    <= acc1_d;
      err_q     <= err_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
`ifdef PSUM_SATURATE_EN
      sat_acc_q <= sat_acc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= wr_entry;
  end

  // Storage is not reset, so the head is masked whenever the FIFO is empty.
  assign head     = mem_q[rd_ptr_q];
  assign out_dat  = out_vld ? head[2*ACC_DW-1:0] : '0;
  assign out_last = out_vld & head[2*ACC_DW];
`ifdef PSUM_SATURATE_EN
  assign out_sat  = out_vld & head[2*ACC_DW+1];
`endif

  assign in_stall = stall_q & (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_two_col_psum_accumulator.sv
// Scoreboard bench for two_col_psum_accumulator: directed jobs, expected entries queued at issue,
// a forked monitor pops and compares on every output handshake. Honours PSUM_SATURATE_EN.
module tb_two_col_psum_accumulator;

  localparam int IN_DW      = 21;
  localparam int ACC_DW     = IN_DW + 1;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int MAC_LAT    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic [CNT_W-1:0]    cfg_k_iter;
  logic [CNT_W-1:0]    cfg_num_out;
  logic                in_vld;
  logic [2*IN_DW-1:0]  in_dat;
  logic                in_stall;
  logic                out_vld;
  logic                out_rdy;
  logic [2*ACC_DW-1:0] out_dat;
  logic                out_last;
  logic                busy;
  logic                done;
  logic                err;
`ifdef PSUM_SATURATE_EN
  logic                out_sat;
`endif

  typedef struct {
    logic [2*ACC_DW-1:0] dat;
    logic                last;
    logic                sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pop_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;

  logic               pv [4];
  logic [2*IN_DW-1:0] pd [4];

  two_col_psum_accumulator #(
    .IN_DW(IN_DW), .ACC_DW(ACC_DW), .CNT_W(CNT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_k_iter(cfg_k_iter), .cfg_num_out(cfg_num_out),
    .in_vld(in_vld), .in_dat(in_dat), .in_stall(in_stall),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_last(out_last),
    .busy(busy), .done(done),
`ifdef PSUM_SATURATE_EN
    .out_sat(out_sat),
`endif
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*IN_DW-1:0] pack_in(input longint c1, input longint c0);
    logic [63:0] a, b;
    a = c0;
    b = c1;
    return {b[IN_DW-1:0], a[IN_DW-1:0]};
  endfunction

  function automatic logic [2*ACC_DW-1:0] pack_out(input longint c1, input longint c0);
    logic [63:0] a, b;
    a = c0;
    b = c1;
    return {b[ACC_DW-1:0], a[ACC_DW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectEntry(input longint c1, input longint c0, input logic last, input logic sat);
    exp_t e;
    e.dat  = pack_out(c1, c0);
    e.last = last;
    e.sat  = sat;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input longint c1, input longint c0);
    in_vld = 1'b1;
    in_dat = pack_in(c1, c0);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic startJob(input int k, input int n);
    cfg_start   = 1'b1;
    cfg_k_iter  = CNT_W'(k);
    cfg_num_out = CNT_W'(n);
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    checkOutput("job_complete_busy", busy, 0);
    tick();
    tick();
  endtask

  // Output side: compare every accepted head against the scoreboard, and log done pulses.
  task automatic monitor();
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_vld && out_rdy) begin
          checks++;
          pop_cyc = cyc;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL out_unexpected: actual dat=%h last=%b required no output", out_dat, out_last);
          end else begin
            e = sb.pop_front();
            bad = (out_dat !== e.dat) || (out_last !== e.last);
`ifdef PSUM_SATURATE_EN
            bad = bad || (out_sat !== e.sat);
            if (bad) begin
              errors++;
              $display("[TB] FAIL out_entry: actual dat=%h last=%b sat=%b required dat=%h last=%b sat=%b",
                       out_dat, out_last, out_sat, e.dat, e.last, e.sat);
            end
`else
            if (bad) begin
              errors++;
              $display("[TB] FAIL out_entry: actual dat=%h last=%b required dat=%h last=%b",
                       out_dat, out_last, e.dat, e.last);
            end
`endif
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  initial begin
    int issued, delivered;
    logic saw_stall;

    rst = 1'b1; cfg_start = 1'b0; cfg_k_iter = '0; cfg_num_out = '0;
    in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
    repeat (3) tick();
    checkOutput("reset_out_vld", out_vld, 0);
    checkOutput("reset_out_dat", out_dat, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_in_stall", in_stall, 0);
    rst = 1'b0;
    tick();
    fork
      monitor();
    join_none

    $display("[TB] basic accumulate K=3 N=2");
    out_rdy = 1'b1;
    done_cnt = 0;
    startJob(3, 2);
    applyStimulus(-4, 5);
    applyStimulus(-4, -2);
    expectEntry(-12, 10, 1'b0, 1'b0);
    applyStimulus(-4, 7);
    applyStimulus(100, 1);
    applyStimulus(0, 1);
    expectEntry(0, 3, 1'b1, 1'b0);
    applyStimulus(-100, 1);
    waitIdle(50);
    checkOutput("basic_done_count", done_cnt, 1);
    checkOutput("basic_done_delay", done_cyc - pop_cyc, 2);
    checkOutput("basic_err", err, 0);

    $display("[TB] K=0 treated as 1, sign extension of most negative input");
    done_cnt = 0;
    startJob(0, 2);
    expectEntry(7, -1048576, 1'b0, 1'b0);
    applyStimulus(7, -1048576);
    expectEntry(-1, -3, 1'b1, 1'b0);
    applyStimulus(-1, -3);
    waitIdle(50);
    checkOutput("k0_done_count", done_cnt, 1);

    $display("[TB] N=0 job");
    startJob(5, 0);
    checkOutput("n0_busy_entered", busy, 1);
    checkOutput("n0_done_early", done, 0);
    tick();
    checkOutput("n0_done_pulse", done, 1);
    checkOutput("n0_busy_after", busy, 0);
    checkOutput("n0_out_vld", out_vld, 0);
    tick();
    checkOutput("n0_done_single", done, 0);

    $display("[TB] misuse: in_vld in IDLE, cfg_start while busy");
    applyStimulus(1, 1);
    checkOutput("idle_vld_err", err, 1);
    done_cnt = 0;
    startJob(2, 1);
    checkOutput("start_clears_err", err, 0);
    startJob(1, 5);
    applyStimulus(10, -5);
    expectEntry(30, -10, 1'b1, 1'b0);
    applyStimulus(20, -5);
    waitIdle(50);
    checkOutput("ignored_start_done", done_cnt, 1);
    checkOutput("ignored_start_err", err, 0);

    $display("[TB] reset mid-job");
    out_rdy = 1'b0;
    done_cnt = 0;
    startJob(1, 4);
    applyStimulus(1, 1);
    applyStimulus(2, 2);
    rst = 1'b1;
    tick();
    checkOutput("midrst_out_vld", out_vld, 0);
    checkOutput("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("midrst_no_done", done_cnt, 0);
    out_rdy = 1'b1;
    startJob(2, 1);
    applyStimulus(3, 4);
    expectEntry(8, -2, 1'b1, 1'b0);
    applyStimulus(5, -6);
    waitIdle(50);
    checkOutput("midrst_new_job_done", done_cnt, 1);

    $display("[TB] backpressure K=1 N=20 with obedient feeder");
    out_rdy = 1'b0;
    startJob(1, 20);
    for (int j = 0; j < 4; j++) begin
      pv[j] = 1'b0;
      pd[j] = '0;
    end
    issued = 0;
    delivered = 0;
    saw_stall = 1'b0;
    for (int step = 0; step < 600; step++) begin
      if (in_vld) delivered++;
      if (in_stall && !saw_stall) begin
        saw_stall = 1'b1;
        checkOutput("stall_onset_pushes", delivered, 4);
      end
      out_rdy = (step >= 30);
      in_vld = pv[3];
      in_dat = pd[3];
      for (int j = 3; j > 0; j--) begin
        pv[j] = pv[j-1];
        pd[j] = pd[j-1];
      end
      pv[0] = 1'b0;
      if (issued < 20 && !in_stall) begin
        pv[0] = 1'b1;
        pd[0] = pack_in(1000 - issued*50, issued*3 - 7);
        expectEntry(1000 - issued*50, issued*3 - 7, issued == 19, 1'b0);
        issued++;
      end
      if (issued == 20 && !pv[0] && !pv[1] && !pv[2] && !pv[3] && !in_vld) break;
      tick();
    end
    in_vld = 1'b0;
    checkOutput("feeder_issued", issued, 20);
    checkOutput("stall_seen", saw_stall, 1);
    waitIdle(100);
    checkOutput("backpressure_err", err, 0);
    checkOutput("backpressure_sb_empty", sb.size(), 0);

    $display("[TB] overflow K=1 N=12, feeder ignores stall");
    out_rdy = 1'b0;
    startJob(1, 12);
    for (int i = 0; i < 12; i++) begin
      if (i < 8) expectEntry(i*10 + 1, -i, 1'b0, 1'b0);
      applyStimulus(i*10 + 1, -i);
    end
    checkOutput("overflow_err", err, 1);
    checkOutput("overflow_out_vld", out_vld, 1);
    out_rdy = 1'b1;
    waitIdle(50);
    checkOutput("overflow_sb_empty", sb.size(), 0);

    $display("[TB] accumulate max positive four times");
    startJob(4, 1);
`ifdef PSUM_SATURATE_EN
    expectEntry(-4, 2097151, 1'b1, 1'b1);
`else
    expectEntry(-4, -4, 1'b1, 1'b0);
`endif
    repeat (4) applyStimulus(-1, 1048575);
    waitIdle(50);
`ifdef PSUM_SATURATE_EN
    checkOutput("sat_err", err, 1);
`else
    checkOutput("wrap_err", err, 0);
`endif
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/two_col_psum_accumulator.md
Name: two_col_psum_accumulator

Overview:
Consumer end of the two-column MAC datapath. Takes the per-cycle two-column Tin-reduced partial sums and accumulates them over K input-channel chunks per output point. Completed output pairs go into a small output FIFO, which drains to the requantiser/writeback stage over a valid/ready handshake. Because the MAC pipeline has no backpressure, the block issues an early stall so the feeder stops issuing before the FIFO can overflow.

Parameters:
IN_DW, 21, width of one column partial sum (MAX_DW2+base_log2Tin); two's complement.
ACC_DW, 32, accumulator width per column; must be ≥ IN_DW.
CNT_W, 16, width of the chunk and output counters.
FIFO_DEPTH, 8, output FIFO entries; power of 2, ≥ MAC_LAT+2.
MAC_LAT, 4, number of partial sums that can still be in flight after in_stall rises.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_start  in  1  pulse; latches cfg_k_iter and cfg_num_out
cfg_k_iter  in  CNT_W  chunks per output point (0 is treated as 1)
cfg_num_out  in  CNT_W  output pairs per job (0 means immediate done)
in_vld  in  1  partial-sum valid
in_dat  in  2*IN_DW  {col1, col0}; col0 in the low bits
in_stall  out  1  feeder must stop issuing new MAC work
out_vld  out  1  FIFO head valid
out_rdy  in  1  downstream accept
out_dat  out  2*ACC_DW  {col1, col0} accumulated result
out_last  out  1  head entry is the final output of the job
busy  out  1  state ≠ IDLE
done  out  1  one-cycle pulse at job end
err  out  1  sticky; cleared by rst or cfg_start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; accumulators and counters cleared.
- FSM has three states: IDLE, ACCUM, DRAIN.
- IDLE:
  - cfg_start latches the configuration, clears k_cnt, out_cnt and err.
  - Next state is ACCUM, or DRAIN if cfg_num_out = 0.
  - in_vld in IDLE is dropped and sets err.
- ACCUM, on each in_vld:
  - Sign-extend each column to ACC_DW.
  - If k_cnt = 0, acc ← in; otherwise acc ← acc + in.
  - When k_cnt = K−1: push the result (including the current input) into the FIFO, reset k_cnt to 0, increment out_cnt. The entry's last bit is (out_cnt = N−1).
  - When the last push happens, next state is DRAIN.
  - Cycles without in_vld hold acc and k_cnt unchanged.
- DRAIN:
  - When the FIFO is empty, pulse done for one cycle and go to IDLE.
  - in_vld in DRAIN is dropped and sets err.
- cfg_start while busy is ignored; the latched configuration is unchanged.
- Latency: the final chunk sampled at edge t gives out_vld = 1 after edge t (registered write, show-ahead FIFO). With K = 1, one pair per cycle is sustained.
- Output handshake:
  - An entry is popped when out_vld & out_rdy.
  - out_dat and out_last are stable while out_vld & !out_rdy.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push on full FIFO drops the data and sets err; FIFO contents are not corrupted.
- Stall:
  - in_stall = (fifo_count ≥ FIFO_DEPTH − MAC_LAT − 1), registered, so it asserts one cycle late.
  - The threshold includes that one cycle of margin.
  - in_stall is forced to 0 in IDLE.
- Arithmetic without the optional feature: two's-complement wrap modulo 2^ACC_DW.
- Reset mid-job: FIFO is flushed, the job is abandoned, done is not pulsed.

Optional Feature:
PSUM_SATURATE_EN
- Defined: each column addition saturates to [−2^(ACC_DW−1), 2^(ACC_DW−1)−1].
  - Any saturation event sets err.
  - The entry's sat bit is carried through the FIFO and ORed into an extra output port, out_sat (1 bit, reset 0), valid with out_vld.
- Undefined: wrap arithmetic; out_sat is absent; no saturation logic or FIFO bit is synthesised.

Test Plan:
- Basic accumulate: K=3, N=2, out_rdy=1. Stream col0 = 5, −2, 7 / 1, 1, 1 and col1 = −4, −4, −4 / 100, 0, −100. Expect {−12, 10} then {0, 3}; second entry has out_last=1. done pulses once, one cycle after the FIFO empties.
- Backpressure: K=1, N=20, out_rdy=0 for 30 cycles. Feeder obeys in_stall and has 4 in flight. in_stall rises at count ≥ 3; no err; all 20 results emerge in order once out_rdy=1.
- Overflow: forced K=1, out_rdy=0, feeder ignores in_stall for 12 pushes. FIFO holds the first 8 entries intact; err=1.
- Edge config and sign extension:
  - cfg_k_iter=0 behaves as K=1.
  - cfg_num_out=0 → done one cycle after DRAIN is entered, no outputs.
  - in_dat col0 = −2^(IN_DW−1) sign-extends correctly.
- Misuse and reset: cfg_start while busy is ignored. in_vld in IDLE sets err. rst asserted mid-job → out_vld=0 and busy=0 next cycle; a new job then produces correct results.
- PSUM_SATURATE_EN, ACC_DW=IN_DW+1: accumulate the max positive value 4 times → result is 2^(ACC_DW−1)−1 with out_sat=1 and err=1. Without the macro the result wraps to the expected modular value.
